// File: rtl/alu.sv
// Execute-stage ALU: combinational result over two WIDTH-bit operands,
// registered onto z each rising clock edge; asynchronous active-high reset.
module alu #(
  parameter int WIDTH = 16
) (
  output logic [WIDTH-1:0] z,
  input  logic [4:0]       ALUop,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             clk,
  input  logic             reset
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_NOT   = 5'b00101;
  localparam logic [4:0] OP_NEG   = 5'b00110;
  localparam logic [4:0] OP_SHL   = 5'b00111;
  localparam logic [4:0] OP_SHR   = 5'b01000;
  localparam logic [4:0] OP_SRA   = 5'b01001;
  localparam logic [4:0] OP_ROL   = 5'b01010;
  localparam logic [4:0] OP_SLT   = 5'b01011;
  localparam logic [4:0] OP_SLTU  = 5'b01100;
  localparam logic [4:0] OP_MUL   = 5'b01101;
  localparam logic [4:0] OP_PASSX = 5'b01110;
  localparam logic [4:0] OP_PASSY = 5'b01111;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] a,
                                            input logic [3:0]       sh);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[(i + int'(sh)) % WIDTH] = a[i];
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] flag(input logic b);
    return {{(WIDTH-1){1'b0}}, b};
  endfunction

  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;
  logic [3:0]              sh;
  logic [WIDTH-1:0]        r_p0;

  assign xs = $signed(X);
  assign ys = $signed(Y);
  assign sh = Y[3:0];

  // stage p0: combinational result select
  always_comb begin
    r_p0 = '0;
    unique case (ALUop)
      OP_ADD:   r_p0 = X + Y;
      OP_SUB:   r_p0 = X - Y;
      OP_AND:   r_p0 = X & Y;
      OP_OR:    r_p0 = X | Y;
      OP_XOR:   r_p0 = X ^ Y;
      OP_NOT:   r_p0 = ~X;
      OP_NEG:   r_p0 = '0 - X;
      OP_SHL:   r_p0 = X << sh;
      OP_SHR:   r_p0 = X >> sh;
      OP_SRA:   r_p0 = $unsigned(xs >>> sh);
      OP_ROL:   r_p0 = rotl(X, sh);
      OP_SLT:   r_p0 = flag(xs < ys);
      OP_SLTU:  r_p0 = flag(X < Y);
      OP_MUL:   r_p0 = X * Y;
      OP_PASSX: r_p0 = X;
      OP_PASSY: r_p0 = Y;
      default:  r_p0 = '0;
    endcase
  end

  // stage p1: registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) z <= '0;
    else       z <= r_p0;
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset behaviour, every op class, wrap and
// shift-amount boundaries, and a back-to-back issue run.
module tb_alu;

  logic [15:0] z;
  logic [4:0]  ALUop;
  logic [15:0] X;
  logic [15:0] Y;
  logic        clk;
  logic        reset;

  int n_cmp = 0;
  int n_bad = 0;

  alu #(.WIDTH(16)) dut (
    .z(z), .ALUop(ALUop), .X(X), .Y(Y), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge register, sample 1ns later.
  task automatic run(input string tag, input logic [4:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp);
    @(negedge clk);
    ALUop = op; X = a; Y = b;
    @(posedge clk);
    #1;
    check(tag, z, exp);
  endtask

  logic [4:0]  bb_op [8];
  logic [15:0] bb_x  [8];
  logic [15:0] bb_y  [8];
  logic [15:0] bb_e  [8];

  initial begin
    reset = 1'b1; ALUop = 5'b01110; X = 16'h5555; Y = 16'h0000;
    #1;
    check("reset_initial", z, 16'h0000);
    @(posedge clk); #1;
    check("reset_hold_edge", z, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-cycle with z holding 0x1234
    run("passx_1234", 5'b01110, 16'h1234, 16'h0000, 16'h1234);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", z, 16'h0000);
    @(posedge clk); #1;
    check("reset_edge1", z, 16'h0000);
    @(posedge clk); #1;
    check("reset_edge2", z, 16'h0000);
    @(negedge clk);
    ALUop = 5'b00000; X = 16'h0002; Y = 16'h0003;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_release_load", z, 16'h0005);

    // Arithmetic wrap
    run("add_wrap",  5'b00000, 16'hFFFF, 16'h0001, 16'h0000);
    run("sub_wrap",  5'b00001, 16'h0000, 16'h0001, 16'hFFFF);
    run("neg_one",   5'b00110, 16'h0001, 16'h1234, 16'hFFFF);
    run("mul_wrap",  5'b01101, 16'h0100, 16'h0100, 16'h0000);
    run("mul_neg",   5'b01101, 16'h0003, 16'hFFFF, 16'hFFFD);

    // Logic
    run("and", 5'b00010, 16'hF0F0, 16'hFF00, 16'hF000);
    run("or",  5'b00011, 16'hF0F0, 16'hFF00, 16'hFFF0);
    run("xor", 5'b00100, 16'hF0F0, 16'hFF00, 16'h0FF0);
    run("not", 5'b00101, 16'hF0F0, 16'hFF00, 16'h0F0F);

    // Shifts and rotate
    run("shl_1",    5'b00111, 16'h8001, 16'h0001, 16'h0002);
    run("shr_15",   5'b01000, 16'h8001, 16'h000F, 16'h0001);
    run("sra_4",    5'b01001, 16'h8001, 16'h0004, 16'hF800);
    run("sra_pos",  5'b01001, 16'h4000, 16'h0002, 16'h1000);
    run("rol_1",    5'b01010, 16'h8001, 16'h0001, 16'h0003);
    run("rol_4",    5'b01010, 16'h1234, 16'h0004, 16'h2341);
    run("shl_y16",  5'b00111, 16'h8001, 16'h0010, 16'h8001);

    // Compares, pass-through, reserved
    run("slt_neg",   5'b01011, 16'hFFFF, 16'h0001, 16'h0001);
    run("sltu_neg",  5'b01100, 16'hFFFF, 16'h0001, 16'h0000);
    run("slt_false", 5'b01011, 16'h0001, 16'hFFFF, 16'h0000);
    run("sltu_true", 5'b01100, 16'h0001, 16'hFFFF, 16'h0001);
    run("passx",     5'b01110, 16'hCAFE, 16'hBEEF, 16'hCAFE);
    run("passy",     5'b01111, 16'h1111, 16'hBEEF, 16'hBEEF);
    run("reserved",  5'b10101, 16'h1234, 16'h5678, 16'h0000);

    // Back-to-back, one op per cycle
    bb_op[0] = 5'b00000; bb_x[0] = 16'h1000; bb_y[0] = 16'h0234; bb_e[0] = 16'h1234;
    bb_op[1] = 5'b00001; bb_x[1] = 16'h0010; bb_y[1] = 16'h0011; bb_e[1] = 16'hFFFF;
    bb_op[2] = 5'b00010; bb_x[2] = 16'h0FF0; bb_y[2] = 16'h00FF; bb_e[2] = 16'h00F0;
    bb_op[3] = 5'b00111; bb_x[3] = 16'h0001; bb_y[3] = 16'h0008; bb_e[3] = 16'h0100;
    bb_op[4] = 5'b01101; bb_x[4] = 16'h0012; bb_y[4] = 16'h0010; bb_e[4] = 16'h0120;
    bb_op[5] = 5'b01001; bb_x[5] = 16'hF000; bb_y[5] = 16'h000C; bb_e[5] = 16'hFFFF;
    bb_op[6] = 5'b01111; bb_x[6] = 16'h0000; bb_y[6] = 16'hA5A5; bb_e[6] = 16'hA5A5;
    bb_op[7] = 5'b00110; bb_x[7] = 16'h0002; bb_y[7] = 16'h0000; bb_e[7] = 16'hFFFE;
    for (int i = 0; i < 8; i++) begin
      run($sformatf("b2b_%0d", i), bb_op[i], bb_x[i], bb_y[i], bb_e[i]);
    end

    // Input change between edges must not disturb z
    @(negedge clk);
    ALUop = 5'b01110; X = 16'h7777;
    #2;
    check("hold_between_edges", z, 16'hFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
